// File: rtl/udma_hyper_rx_buffer.sv
// rtl/udma_hyper_rx_buffer.sv - elastic FIFO between HyperBus read data and the uDMA RX channel
// Define HYPER_RX_BUF_HWM_EN to add the peak-occupancy register and hwm_o port.
module udma_hyper_rx_buffer #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8,
    parameter int TRANS_SIZE   = 16
) (
    input  logic                            sys_clk_i,
    input  logic                            rst_i,
    input  logic                            clr_i,
    input  logic [1:0]                      cfg_datasize_i,
    input  logic [DATA_WIDTH-1:0]           data_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    output logic [DATA_WIDTH-1:0]           data_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [TRANS_SIZE-1:0]           bytes_o,
    output logic [$clog2(BUFFER_DEPTH):0]   elements_o,
    output logic                            full_o,
`ifdef HYPER_RX_BUF_HWM_EN
    output logic [$clog2(BUFFER_DEPTH):0]   hwm_o,
`endif
    output logic                            empty_o
);

    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic [TRANS_SIZE-1:0] bytes_q;
    logic [2:0]            byte_inc;
    logic                  push;
    logic                  pop;

    assign full_o     = (count == CW'(BUFFER_DEPTH));
    assign empty_o    = (count == '0);
    // No pass-through: a full buffer refuses data even if it is popped this cycle.
    assign ready_o    = !full_o && !clr_i;
    assign valid_o    = !empty_o;
    assign data_o     = mem[rd_ptr];
    assign elements_o = count;
    assign bytes_o    = bytes_q;

    assign push = valid_i && ready_o;
    assign pop  = valid_o && ready_i;

    always_comb begin
        byte_inc = 3'd4;
        case (cfg_datasize_i)
            2'd0:    byte_inc = 3'd1;
            2'd1:    byte_inc = 3'd2;
            default: byte_inc = 3'd4;
        endcase
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // clr_i outranks any handshake in the same cycle.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            bytes_q <= '0;
        end else if (clr_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            bytes_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                bytes_q <= bytes_q + TRANS_SIZE'(byte_inc);
            end
            count <= count_next;
        end
    end

`ifdef HYPER_RX_BUF_HWM_EN
    logic [CW-1:0] hwm_q;

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            hwm_q <= '0;
        end else if (clr_i) begin
            hwm_q <= '0;
        end else if (count_next > hwm_q) begin
            hwm_q <= count_next;
        end
    end

    assign hwm_o = hwm_q;
`endif

endmodule

// File: tb/tb_udma_hyper_rx_buffer.sv
// tb/tb_udma_hyper_rx_buffer.sv - randomized queue-model bench for udma_hyper_rx_buffer
module tb_udma_hyper_rx_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int TS    = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          clr_i;
    logic [1:0]    cfg_datasize_i;
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic [TS-1:0] bytes_o;
    logic [3:0]    elements_o;
    logic          full_o;
    logic          empty_o;
`ifdef HYPER_RX_BUF_HWM_EN
    logic [3:0]    hwm_o;
`endif

    udma_hyper_rx_buffer #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .TRANS_SIZE(TS)) dut (
        .sys_clk_i      (clk),
        .rst_i          (rst_i),
        .clr_i          (clr_i),
        .cfg_datasize_i (cfg_datasize_i),
        .data_i         (data_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .bytes_o        (bytes_o),
        .elements_o     (elements_o),
        .full_o         (full_o),
`ifdef HYPER_RX_BUF_HWM_EN
        .hwm_o          (hwm_o),
`endif
        .empty_o        (empty_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mq[$];
    int            mbytes;
    int            mhwm;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mbytes = 0;
        mhwm   = 0;
    endtask

    task automatic check_outputs();
        check("elements", 64'(elements_o), 64'(mq.size()));
        check("empty", 64'(empty_o), 64'(mq.size() == 0));
        check("full", 64'(full_o), 64'(mq.size() == DEPTH));
        check("valid_o", 64'(valid_o), 64'(mq.size() != 0));
        check("bytes", 64'(bytes_o), 64'(mbytes % (1 << TS)));
        if (mq.size() != 0) check("data_o", 64'(data_o), 64'(mq[0]));
`ifdef HYPER_RX_BUF_HWM_EN
        check("hwm", 64'(hwm_o), 64'(mhwm));
`endif
    endtask

    // Called just after a falling edge; applies one cycle of stimulus and checks the result.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic c,
                        input logic [1:0] ds);
        bit acc, take;
        valid_i = v; data_i = d; ready_i = r; clr_i = c; cfg_datasize_i = ds;
        #1;
        check("ready_o", 64'(ready_o), 64'(mq.size() < DEPTH && !c));
        acc  = v && (mq.size() < DEPTH) && !c;
        take = r && (mq.size() > 0) && !c;
        if (c) begin
            model_reset();
        end else begin
            if (take) begin
                mbytes += (ds == 2'd0) ? 1 : (ds == 2'd1) ? 2 : 4;
                void'(mq.pop_front());
            end
            if (acc) mq.push_back(d);
            if (mq.size() > mhwm) mhwm = mq.size();
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst_i = 1'b1; clr_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        data_i = '0; cfg_datasize_i = 2'd2;
        model_reset();
        @(negedge clk);
        check("rst_data_o", 64'(data_o), 64'd0);
        check("rst_ready_o", 64'(ready_o), 64'd1);
        check_outputs();
        rst_i = 1'b0;

        // latency and first pop
        step(1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 2'd2);
        check("first_data", 64'(data_o), 64'hA5A5_0001);
        step(1'b0, 32'h0, 1'b1, 1'b0, 2'd2);
        check("first_bytes", 64'(bytes_o), 64'd4);

        // fill to full, refused ninth push, drain in order
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h100 + i, 1'b0, 1'b0, 2'd2);
        check("full_reached", 64'(full_o), 64'd1);
        step(1'b1, 32'hDEAD, 1'b0, 1'b0, 2'd2);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", 64'(data_o), 64'(32'h100 + i));
            step(1'b0, 32'h0, 1'b1, 1'b0, 2'd2);
        end

        // steady state push+pop at occupancy 3
        for (int i = 0; i < 3; i++) step(1'b1, 32'h200 + i, 1'b0, 1'b0, 2'd2);
        for (int i = 0; i < 20; i++) step(1'b1, 32'h300 + i, 1'b1, 1'b0, 2'd2);
        check("steady_occ", 64'(elements_o), 64'd3);

        // datasize counting with 4-bit wrap
        step(1'b0, 32'h0, 1'b0, 1'b1, 2'd0);
        step(1'b1, 32'h400, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 17; i++) step(1'b1, 32'h401 + i, 1'b1, 1'b0, 2'd0);
        check("wrap_bytes", 64'(bytes_o), 64'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 2'd1);
        check("half_bytes", 64'(bytes_o), 64'd3);

        // clear while pushing and popping
        for (int i = 0; i < 5; i++) step(1'b1, 32'h500 + i, 1'b0, 1'b0, 2'd2);
        step(1'b1, 32'h5FF, 1'b1, 1'b1, 2'd2);
        check("clr_empty", 64'(empty_o), 64'd1);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 99) < 2), 2'($urandom_range(0, 3)));

        // async reset mid-burst at occupancy 6
        step(1'b0, 32'h0, 1'b0, 1'b1, 2'd2);
        for (int i = 0; i < 6; i++) step(1'b1, 32'h600 + i, 1'b0, 1'b0, 2'd2);
        step(1'b1, 32'h700, 1'b1, 1'b0, 2'd2);
        valid_i = 1'b1; ready_i = 1'b1;
        #2 rst_i = 1'b1;
        #1;
        model_reset();
        check("arst_data_o", 64'(data_o), 64'd0);
        check("arst_ready_o", 64'(ready_o), 64'd1);
        check_outputs();
        rst_i = 1'b0;
        valid_i = 1'b0; ready_i = 1'b0;
        @(negedge clk);
        check_outputs();
        step(1'b1, 32'h800, 1'b1, 1'b0, 2'd2);
        step(1'b0, 32'h0, 1'b1, 1'b0, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udma_hyper_rx_buffer.md
# udma_hyper_rx_buffer

Elastic receive buffer between the HyperBus controller's 32-bit read-data output and the uDMA RX channel. It absorbs back-pressure from the uDMA core so that HyperBus read bursts are not stalled by L2 arbitration. It counts bytes delivered according to the channel datasize and reports fill level for debug and flow control.

## Interface
- DATA_WIDTH, 32, width of a data element
- BUFFER_DEPTH, 8, number of entries; power of two, at least 2
- TRANS_SIZE, 16, width of the delivered-byte counter
- sys_clk_i  in  1  block clock; all logic on its rising edge
- rst_i  in  1  asynchronous, active-high reset
- clr_i  in  1  synchronous flush of buffer and counter
- cfg_datasize_i  in  2  RX datasize: 0 = byte, 1 = half-word, 2 or 3 = word
- data_i  in  DATA_WIDTH  read data from the HyperBus controller
- valid_i  in  1  data_i valid
- ready_o  out  1  buffer accepts data_i
- data_o  out  DATA_WIDTH  head-of-buffer data to the uDMA RX channel
- valid_o  out  1  data_o valid
- ready_i  in  1  uDMA RX channel accepts data_o
- bytes_o  out  TRANS_SIZE  bytes delivered since reset or clear
- elements_o  out  $clog2(BUFFER_DEPTH)+1  current occupancy
- full_o  out  1  occupancy == BUFFER_DEPTH
- empty_o  out  1  occupancy == 0
- hwm_o  out  $clog2(BUFFER_DEPTH)+1  peak occupancy; only present with HYPER_RX_BUF_HWM_EN

## Operation
- Circular buffer with write pointer, read pointer and occupancy counter. Pointers are $clog2(BUFFER_DEPTH) bits wide and wrap naturally.
- Push occurs when valid_i && ready_o: data_i is written at the write pointer, and the write pointer increments.
- Pop occurs when valid_o && ready_i: the read pointer increments.
- ready_o = !full_o && !clr_i. There is no pass-through path, so a push is never accepted when full, even if a pop happens in the same cycle.
- valid_o = !empty_o. data_o = mem[read pointer]. When empty_o is high, data_o content is don't-care.
- Occupancy is updated as follows:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- bytes_o increments on every pop. The increment is 1, 2 or 4 according to cfg_datasize_i sampled in the pop cycle. The counter wraps modulo 2^TRANS_SIZE.
- clr_i has priority over push and pop in the same cycle. It zeroes both pointers, the occupancy count, bytes_o and hwm_o. Buffer contents are not cleared.
- Holding ready_i low never drops or reorders data. Order is strictly first-in, first-out.
- cfg_datasize_i changes take effect on the next pop and have no effect on stored data.

## Timing
- Reset values:
  - valid_o = 0, data_o = 0
  - ready_o = 1 (once clr_i is low)
  - bytes_o = 0, elements_o = 0, empty_o = 1, full_o = 0
  - hwm_o = 0, all memory entries = 0
- Latency: a push in cycle N makes valid_o high in cycle N+1, with that data on data_o if the buffer was empty.
- Full boundary:
  - A push that fills the buffer drops ready_o in the next cycle.
  - A pop from a full buffer raises ready_o in the next cycle.
- Empty boundary: a pop of the last entry drops valid_o in the next cycle, unless a push happened in the same cycle.
- Status outputs (elements_o, full_o, empty_o, bytes_o, hwm_o) are registered or derived from registered state only; they have no combinational path from inputs.
- rst_i asserted mid-burst immediately returns all state to its reset values. In-flight data is discarded.
- Once reset is released, the block is operational in the first clock cycle.

## Configuration
- HYPER_RX_BUF_HWM_EN:
  - When defined, a high-water-mark register is compiled in. It updates to the new occupancy whenever the new occupancy exceeds the current hwm_o, is cleared by rst_i or clr_i, and drives hwm_o.
  - When undefined, the register and the hwm_o port are absent, and all other behaviour is identical.

## Test plan
- Latency and ordering: after reset, push 0xA5A5_0001 with ready_i=1 -> valid_o=1 and data_o=0xA5A5_0001 in the next cycle; bytes_o=4 after the pop when cfg_datasize_i=2.
- Fill to full: with BUFFER_DEPTH=8 and ready_i=0, push 8 words -> full_o=1, ready_o=0, elements_o=8. A 9th valid_i is not accepted. Then set ready_i=1 -> words 0..7 come out in order, and bytes_o=32.
- Simultaneous push and pop at steady state: occupancy 3, both handshakes for 20 cycles -> elements_o stays 3, no loss, and pointers wrap correctly past index 7.
- Datasize counting and wrap: TRANS_SIZE=4, cfg_datasize_i=0, 17 pops -> bytes_o=1. Then switch to datasize 1 and do 1 pop -> bytes_o=3.
- Clear during activity: occupancy 5, assert clr_i together with valid_i and ready_i -> the next cycle has elements_o=0, empty_o=1, bytes_o=0, and the concurrent push is not stored.
- Async reset mid-burst (HYPER_RX_BUF_HWM_EN defined): reach occupancy 6 (hwm_o=6), then pulse rst_i between clock edges -> all outputs return to their reset values immediately and hwm_o=0.
